// File: rtl/f_stage_pkg.sv
// -----------------------------------------------------------------------------
// f_stage_pkg
// Shared constants for the P7 pipeline: fetch address map, exception vector
// and CP0 ExcCode values. Intended for reuse by the D/E/M stages and CP0.
// -----------------------------------------------------------------------------
package f_stage_pkg;

  // Address map
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

  // CP0 ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // True when a word access at addr is misaligned or outside [base, top].
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > top);
  endfunction

endpackage

// File: rtl/f_stage_npc_sel.sv
// -----------------------------------------------------------------------------
// f_stage_npc_sel
// Combinational next-PC priority mux for the fetch stage.
// Priority: req > (hold when en=0) > eret_d > redirect_d > pc+4.
// Reset is applied by the PC register in f_stage, not here.
// Ports:
//   pc_i         current PC
//   en_i         advance enable (0 = stall)
//   req_i        exception/interrupt request
//   eret_i       eret decoded in D
//   epc_i        eret return target
//   redirect_i   taken branch/jump resolved in D
//   target_i     redirect target
//   npc_o        next PC
// -----------------------------------------------------------------------------
module f_stage_npc_sel
  import f_stage_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_PC
) (
  input  logic [31:0] pc_i,
  input  logic        en_i,
  input  logic        req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_i + 32'd4;
    // An exception request must be taken even during a stall.
    if (req_i)           npc_o = EXC_VECTOR;
    else if (!en_i)      npc_o = pc_i;
    else if (eret_i)     npc_o = epc_i;
    else if (redirect_i) npc_o = target_i;
  end

endmodule

// File: rtl/f_stage.sv
// -----------------------------------------------------------------------------
// f_stage
// Instruction-fetch stage of the P7 five-stage MIPS pipeline. Holds the PC,
// selects the next PC, checks the fetch address (AdEL) and counts fetches.
// Outputs are combinational from the PC and the inputs; the F/D register
// downstream captures them.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              PC advance enable (0 = stall)
//   req             exception/interrupt request from CP0
//   eret_d, epc     eret in D and its return target
//   redirect_d      taken branch/jump in D, target_d its target
//   ctrl_d          D holds a branch/jump (F is its delay slot)
//   i_inst_addr     instruction-memory address (raw PC)
//   i_inst_rdata    fetched word
//   pc_f, instr_f, exc_code_f, bd_f   values for the F/D register
//   fetch_cnt       accepted-fetch counter
// -----------------------------------------------------------------------------
module f_stage #(
  parameter logic [31:0] RESET_PC = f_stage_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = f_stage_pkg::EXC_PC,
  parameter logic [31:0] IM_BASE  = f_stage_pkg::IM_BASE,
  parameter logic [31:0] IM_TOP   = f_stage_pkg::IM_TOP,
  parameter logic [4:0]  EXC_ADEL = f_stage_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic        redirect_d,
  input  logic [31:0] target_d,
  input  logic        ctrl_d,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic [4:0]  exc_code_f,
  output logic        bd_f,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        adel;

  f_stage_npc_sel #(
    .EXC_VECTOR (EXC_PC)
  ) u_npc_sel (
    .pc_i       (pc_q),
    .en_i       (en),
    .req_i      (req),
    .eret_i     (eret_d),
    .epc_i      (epc),
    .redirect_i (redirect_d),
    .target_i   (target_d),
    .npc_o      (pc_d)
  );

  // Flushed and wrong-path fetches are counted too; only stalls and
  // exception entry suppress the count.
  assign fetch_cnt_d = (en && !req) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign adel = f_stage_pkg::addr_bad(pc_q, IM_BASE, IM_TOP);

  assign i_inst_addr = pc_q;
  assign pc_f        = pc_q;
  assign exc_code_f  = adel ? EXC_ADEL : 5'd0;
  // The word after eret is a wrong-path fetch; eret has no delay slot.
  assign instr_f     = (adel || eret_d) ? 32'd0 : i_inst_rdata;
  // Kept even on AdEL so EPC of a faulting delay slot points at the branch.
  assign bd_f        = ctrl_d;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_f_stage.sv
// -----------------------------------------------------------------------------
// tb_f_stage
// Self-checking bench for f_stage: directed scenarios followed by randomized
// cycles, checked against a behavioural fetch model.
// -----------------------------------------------------------------------------
module tb_f_stage;

  localparam logic [31:0] P_RESET = 32'h0000_3000;
  localparam logic [31:0] P_EXC   = 32'h0000_4180;
  localparam logic [31:0] P_BASE  = 32'h0000_3000;
  localparam logic [31:0] P_TOP   = 32'h0000_6FFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en = 1'b0, req = 1'b0, eret_d = 1'b0, redirect_d = 1'b0, ctrl_d = 1'b0;
  logic [31:0] epc = 32'd0, target_d = 32'd0;
  logic [31:0] i_inst_addr, i_inst_rdata, pc_f, instr_f, fetch_cnt;
  logic [4:0]  exc_code_f;
  logic        bd_f;

  // Instruction memory stand-in: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  f_stage dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .req          (req),
    .eret_d       (eret_d),
    .epc          (epc),
    .redirect_d   (redirect_d),
    .target_d     (target_d),
    .ctrl_d       (ctrl_d),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .pc_f         (pc_f),
    .instr_f      (instr_f),
    .exc_code_f   (exc_code_f),
    .bd_f         (bd_f),
    .fetch_cnt    (fetch_cnt)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_pc  = P_RESET;
  logic [31:0] ref_cnt = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, check combinational outputs, let the edge
  // happen, then check the registered PC and counter against the model.
  task automatic step(input logic s_rst, input logic s_en, input logic s_req,
                      input logic s_eret, input logic [31:0] s_epc,
                      input logic s_redir, input logic [31:0] s_tgt,
                      input logic s_ctrl);
    logic        bad;
    logic [31:0] nxt;
    logic [31:0] exp_pc;
    @(negedge clk);
    reset = s_rst; en = s_en; req = s_req; eret_d = s_eret; epc = s_epc;
    redirect_d = s_redir; target_d = s_tgt; ctrl_d = s_ctrl;
    #1;
    bad = (ref_pc % 4 != 0) || (ref_pc < P_BASE) || (ref_pc > P_TOP);
    check_val("i_inst_addr", i_inst_addr, ref_pc);
    check_val("exc_code_f", {27'd0, exc_code_f}, bad ? 32'd4 : 32'd0);
    check_val("instr_f", instr_f, (bad || s_eret) ? 32'd0 : mem_word(ref_pc));
    check_val("bd_f", {31'd0, bd_f}, {31'd0, s_ctrl});

    if (s_rst)       nxt = P_RESET;
    else if (s_req)  nxt = P_EXC;
    else if (!s_en)  nxt = ref_pc;
    else if (s_eret) nxt = s_epc;
    else if (s_redir) nxt = s_tgt;
    else             nxt = ref_pc + 4;
    if (s_rst)                ref_cnt = 0;
    else if (s_en && !s_req)  ref_cnt = ref_cnt + 1;
    ref_pc = nxt;
    exp_q.push_back(nxt);

    @(posedge clk);
    #1;
    exp_pc = exp_q.pop_front();
    check_val("pc_f", pc_f, exp_pc);
    check_val("fetch_cnt", fetch_cnt, ref_cnt);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return P_BASE + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
    else if (r == 1) return $urandom();
    else             return P_BASE + 4 * $urandom_range(0, 4095);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);              // reset with req and en
    seq(4);                                    // 3000 -> 3010
    step(0, 1, 0, 0, 0, 1, 32'h3100, 1);       // redirect, bd_f=1
    step(0, 1, 0, 0, 0, 1, 32'h3020, 0);
    step(0, 0, 0, 0, 0, 1, 32'h3200, 1);       // stall with pending redirect
    step(0, 0, 0, 0, 0, 1, 32'h3200, 1);
    step(0, 1, 0, 0, 0, 1, 32'h3200, 1);
    step(0, 1, 0, 0, 0, 1, 32'h3040, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);              // req during stall -> 4180
    step(0, 1, 0, 1, 32'h3044, 0, 0, 0);       // eret -> 3044, instr_f=0
    step(0, 1, 1, 1, 32'h3500, 1, 32'h3600, 1);// req beats eret/redirect
    step(0, 1, 0, 1, 32'h3300, 1, 32'h3400, 0);// eret beats redirect
    step(0, 1, 0, 0, 0, 1, 32'h3002, 0);
    step(0, 1, 0, 0, 0, 1, 32'h7000, 1);       // at 3002: AdEL, bd_f=1
    step(0, 1, 0, 0, 0, 1, 32'h2FFC, 0);       // at 7000: AdEL
    step(0, 1, 0, 0, 0, 1, 32'h6FF8, 1);       // at 2FFC: AdEL
    seq(2);                                    // 6FF8, 6FFC legal, then 7000
    step(0, 0, 0, 0, 0, 0, 0, 0);              // stall at 7000
    step(1, 0, 0, 0, 0, 0, 0, 0);              // reset mid-stall
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0), rand_addr(),
           ($urandom_range(0, 3) == 0), rand_addr(),
           ($urandom_range(0, 1) == 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f_stage.md
Name: f_stage

Overview:
- Instruction-fetch stage of the P7 five-stage MIPS pipeline, directly upstream of the F/D pipeline register.
- Owns the PC register and the next-PC selection: sequential, branch/jump redirect, eret return and exception-vector entry.
- Drives the instruction-memory address and receives the fetched word.
- Produces pc_f, instr_f, exc_code_f and bd_f for the F/D register; these are registered by that register on its next enabled edge.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address.
- EXC_ADEL, 5'd4, ExcCode for fetch address error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  PC advance enable; 0 = stall from the hazard unit.
- req  in  1  exception/interrupt request from CP0.
- eret_d  in  1  eret decoded in D.
- epc  in  32  CP0 EPC, the return target.
- redirect_d  in  1  taken branch or jump resolved in D.
- target_d  in  32  redirect target.
- ctrl_d  in  1  D holds a branch/jump; the instruction in F is its delay slot.
- i_inst_addr  out  32  instruction-memory address; equals pc_f.
- i_inst_rdata  in  32  fetched word, combinational for i_inst_addr.
- pc_f  out  32  current PC.
- instr_f  out  32  instruction for the F/D register.
- exc_code_f  out  5  0 or EXC_ADEL.
- bd_f  out  1  delay-slot flag.
- fetch_cnt  out  32  count of accepted fetches (performance).

Behaviour:
- Reset: pc <= RESET_PC; fetch_cnt <= 0.
- Outputs are combinational from pc and the inputs, so right after reset: pc_f=3000, exc_code_f=0, bd_f=ctrl_d, instr_f=i_inst_rdata.
- PC update priority at each edge: reset > req > eret_d > redirect_d > sequential.
  - req=1: pc <= EXC_PC, even when en=0.
  - Otherwise, if en=0: pc holds, including when eret_d or redirect_d is pending.
  - Otherwise, if eret_d: pc <= epc. eret has no delay slot.
  - Otherwise, if redirect_d: pc <= target_d.
  - Otherwise: pc <= pc+4, with 32-bit wrap and no carry-out.
- AdEL detection, combinational: pc[1:0]!=0 or pc<IM_BASE or pc>IM_TOP -> exc_code_f=EXC_ADEL, else 0.
- instr_f:
  - 0 when exc_code_f!=0.
  - 0 when eret_d=1; this discards the wrong-path fetch following eret.
  - Otherwise i_inst_rdata.
- bd_f = ctrl_d, passed through even when exc_code_f!=0; EPC on a delay-slot AdEL must point to the branch.
- fetch_cnt:
  - Increments by 1 at an edge where en=1, req=0 and reset=0.
  - Counts flushed and wrong-path fetches too.
  - Wraps 0xFFFFFFFF->0.
- Simultaneous events:
  - req with eret_d: req wins.
  - req with redirect_d: req wins; the delay slot is squashed by the F/D register, not here.
  - eret_d with redirect_d cannot both be true by construction; if they are, eret_d wins.
- Reset mid-stall: reset overrides en.
- Reset asserted together with req: pc=RESET_PC.
- i_inst_addr is driven with the raw pc even when misaligned; memory-side effects are ignored.

Decomposition:
- Shared package holds RESET_PC, EXC_PC, IM_BASE, IM_TOP and the ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12) for reuse by the D/E/M stages and CP0.
- One natural sub-module, npc_sel: combinational next-PC priority mux. The PC register, AdEL check and counter stay in f_stage.

Test Plan:
- Reset, then en=1 for 3 cycles, no events -> pc_f 3000, 3004, 3008, 300C; fetch_cnt=3; exc_code_f=0.
- At pc=3010: redirect_d=1, target_d=3100, ctrl_d=1 -> bd_f=1 that cycle; next pc_f=3100.
- en=0 for 2 cycles at pc=3020 with redirect_d=1 -> pc holds 3020 and fetch_cnt frozen; when en rises, next pc=target_d.
- req=1 while en=0 at pc=3040 -> next pc_f=4180; fetch_cnt unchanged that edge.
- eret_d=1, epc=3044 -> instr_f=0 that cycle; next pc_f=3044.
- redirect to target 3002, then to 7000 -> exc_code_f=4 and instr_f=0 at each; bd_f follows ctrl_d.
